// File: rtl/digit_scan_ctrl.sv
// Four-digit multiplexed display scanner with a double-buffered value register.
// Define LEADING_ZERO_BLANK_EN to suppress leading zero digits (digit 0 always lit).
module digit_scan_ctrl #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [1:0]  digit,
  output logic [3:0]  ct,
  output logic [3:0]  nibble,
  output logic        frame_done
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LastCnt  = CW'(DIV - 1);
  localparam logic [CW-1:0] BlankCnt = CW'(BLANK);

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    digit_q, digit_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   pending_q, pending_d;
  logic          pend_q, pend_d;
  logic [3:0]    nibble_q, nibble_d;

  logic frame_end;
  logic transfer;
  logic accept;
  logic drive_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      digit_q   <= '0;
      active_q  <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
      nibble_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      digit_q   <= digit_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      nibble_q  <= nibble_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    digit_d = digit_q;
    if (!enable) begin
      state_d = StIdle;
      count_d = '0;
      digit_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StBlank;
          count_d = '0;
          digit_d = '0;
        end
        StBlank, StDrive: begin
          if (count_q == LastCnt) begin
            count_d = '0;
            digit_d = digit_q + 2'd1;
          end else begin
            count_d = count_q + 1'b1;
          end
          state_d = (count_d < BlankCnt) ? StBlank : StDrive;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // The buffer also accepts in the transfer cycle itself: the old pending value moves to
  // active while the offered value takes its place, so load_ready stays low.
  always_comb begin
    frame_end = (state_q == StDrive) && (digit_q == 2'd3) && (count_q == LastCnt);
    transfer  = pend_q && ((state_q == StIdle) || frame_end);
    accept    = load_valid && (!pend_q || transfer);
    active_d  = transfer ? pending_q : active_q;
    pending_d = accept ? value_in : pending_q;
    pend_d    = accept || (pend_q && !transfer);
    nibble_d  = active_d[{digit_d, 2'b00} +: 4];
  end

  always_comb begin
    drive_en = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    case (digit_q)
      2'd3:    drive_en = |active_q[15:12];
      2'd2:    drive_en = |active_q[15:8];
      2'd1:    drive_en = |active_q[15:4];
      default: drive_en = 1'b1;
    endcase
`endif
    ct = 4'b1111;
    if (state_q == StDrive && drive_en) begin
      case (digit_q)
        2'd0:    ct = 4'b0111;
        2'd1:    ct = 4'b1011;
        2'd2:    ct = 4'b1101;
        default: ct = 4'b1110;
      endcase
    end
    load_ready = !pend_q;
    digit      = digit_q;
    nibble     = nibble_q;
    frame_done = frame_end;
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl: directed scenarios plus random traffic,
// compared each cycle against a frame-position model of the scanner.
module tb_digit_scan_ctrl;

  localparam int unsigned DIV   = 8;
  localparam int unsigned BLANK = 2;
  localparam int          FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] value_in;
  logic        load_valid;
  logic        load_ready;
  logic [1:0]  digit;
  logic [3:0]  ct;
  logic [3:0]  nibble;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  // Model: running flag, position within the frame, and the two value buffers.
  bit          m_run;
  int          m_t;
  logic [15:0] m_act;
  logic [15:0] m_pend;
  bit          m_pv;

  digit_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .value_in   (value_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .digit      (digit),
    .ct         (ct),
    .nibble     (nibble),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_t = 0; m_act = '0; m_pend = '0; m_pv = 0;
  endtask

  function automatic int exp_digit();
    return m_run ? m_t / DIV : 0;
  endfunction

  function automatic logic [3:0] exp_nibble();
    logic [15:0] sh;
    sh = m_act >> (4 * exp_digit());
    return sh[3:0];
  endfunction

  function automatic logic [3:0] exp_ct();
    int d;
    d = exp_digit();
    if (!m_run || (m_t % DIV) < BLANK) return 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
    if (d != 0 && (m_act >> (4 * d)) == 16'h0) return 4'hF;
`endif
    return ~(4'b1000 >> d);
  endfunction

  task automatic check_all(input string tag);
    check({tag, "/digit"},  16'(digit),      16'(exp_digit()));
    check({tag, "/ct"},     16'(ct),         16'(exp_ct()));
    check({tag, "/nibble"}, 16'(nibble),     16'(exp_nibble()));
    check({tag, "/fdone"},  16'(frame_done), 16'(m_run && m_t == FRAME - 1));
    check({tag, "/ready"},  16'(load_ready), 16'(!m_pv));
  endtask

  task automatic model_step(input bit en, input bit lv, input logic [15:0] v);
    bit fd, xfer, acc;
    fd   = m_run && (m_t == FRAME - 1);
    xfer = m_pv && (!m_run || fd);
    acc  = lv && (!m_pv || xfer);
    if (xfer) m_act = m_pend;
    if (acc) m_pend = v;
    m_pv = acc || (m_pv && !xfer);
    if (!en) begin
      m_run = 0; m_t = 0;
    end else if (!m_run) begin
      m_run = 1; m_t = 0;
    end else begin
      m_t = (m_t + 1) % FRAME;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check at the next falling edge.
  task automatic step(input bit en, input bit lv, input logic [15:0] v, input string tag);
    enable = en; load_valid = lv; value_in = v;
    model_step(en, lv, v);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic advance_to(input int target);
    for (int k = 0; k < FRAME + 2; k++) begin
      if (m_run && m_t == target) break;
      step(1, 0, 16'h0, "adv");
    end
  endtask

  initial begin
    logic [3:0]  e;
    logic [15:0] sh;
    int          n;

    reset_n = 1'b0; enable = 1'b0; load_valid = 1'b0; value_in = '0;
    model_reset();
    #7;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Load 0x1234 and watch the frame after the first boundary
    step(1, 1, 16'h1234, "r035_load");
    repeat (FRAME) step(1, 0, 16'h0, "r035_wait");
    for (int i = 0; i < FRAME; i++) begin
      e  = ((i % DIV) < BLANK) ? 4'hF : ~(4'b1000 >> (i / DIV));
      sh = 16'h1234 >> (4 * (i / DIV));
      check("r035_ct", 16'(ct), 16'(e));
      check("r035_nibble", 16'(nibble), 16'(sh[3:0]));
      step(1, 0, 16'h0, "r035_frame");
    end

    // Mid-frame load, offers while busy are ignored, display switches at next digit 0
    repeat (5) step(1, 0, 16'h0, "r036_pre");
    step(1, 1, 16'hABCD, "r036_load");
    check("r036_busy", 16'(load_ready), 16'h0);
    repeat (3) step(1, 1, 16'h5555, "r036_offer");
    advance_to(FRAME - 1);
    check("r036_old", 16'(nibble), 16'h1);
    step(1, 0, 16'h0, "r036_wrap");
    check("r036_new", 16'(nibble), 16'hD);
    check("r036_ready", 16'(load_ready), 16'h1);
    advance_to(FRAME - 1);
    check("r036_d3", 16'(nibble), 16'hA);

    // Offer exactly in the frame_done cycle while a value is pending
    step(1, 0, 16'h0, "r037_pre");
    step(1, 1, 16'h1111, "r037_load");
    advance_to(FRAME - 1);
    step(1, 1, 16'h2222, "r037_coinc");
    check("r037_shown", 16'(nibble), 16'h1);
    check("r037_ready", 16'(load_ready), 16'h0);
    advance_to(FRAME - 1);
    step(1, 0, 16'h0, "r037_next");
    check("r037_next", 16'(nibble), 16'h2);

    // Leading-zero values
    step(1, 1, 16'h0040, "r039_load40");
    repeat (2 * FRAME) step(1, 0, 16'h0, "r039_40");
    step(1, 1, 16'h0000, "r039_load0");
    repeat (FRAME) step(1, 0, 16'h0, "r039_0a");
    advance_to(BLANK);
    check("r039_d0ct", 16'(ct), 16'h7);
    check("r039_d0nib", 16'(nibble), 16'h0);
    repeat (FRAME) step(1, 0, 16'h0, "r039_0b");

    // Drop enable during digit 2 DRIVE, then restart
    advance_to(2 * DIV + BLANK + 1);
    step(0, 0, 16'h0, "r038_off");
    check("r038_ct", 16'(ct), 16'hF);
    check("r038_digit", 16'(digit), 16'h0);
    step(0, 0, 16'h0, "r038_off2");
    step(1, 0, 16'h0, "r038_on");
    n = 1;
    while (!frame_done && n < FRAME + 8) begin
      step(1, 0, 16'h0, "r038_run");
      n++;
    end
    check("r038_cycles", 16'(n), 16'(FRAME));

    // Asynchronous reset in the middle of DRIVE with a value pending
    step(1, 0, 16'h0, "r040_pre");
    step(1, 1, 16'hBEEF, "r040_load");
    advance_to(DIV + BLANK + 2);
    #2 reset_n = 1'b0;
    #1;
    check("r040_ct", 16'(ct), 16'hF);
    check("r040_ready", 16'(load_ready), 16'h1);
    check("r040_digit", 16'(digit), 16'h0);
    check("r040_nibble", 16'(nibble), 16'h0);
    model_reset();
    @(negedge clk);
    check_all("r040_held");
    reset_n = 1'b1;
    step(1, 0, 16'h0, "r031_first");

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      bit          en, lv;
      logic [15:0] v;
      en = ($urandom_range(0, 39) != 0);
      lv = ($urandom_range(0, 5) == 0);
      v  = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v = v & 16'h00FF;
        1: v = v & 16'h000F;
        2: v = 16'h0;
        default: ;
      endcase
      step(en, lv, v, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
